// File: rtl/cnn_layer_accel_awe_pkg.sv
// Shared AWE definitions: weight-fetch state encoding, output buffer depth
// and the default kernel size (3x3).
package cnn_layer_accel_awe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } awe_state_e;

  localparam int AWE_BUF_DEPTH = 2;
  localparam int AWE_KSIZE_DEF = 9;

endpackage

// File: rtl/cnn_layer_accel_awe_weight_fetch_if.sv
// Weight-fetch bus: weight-table read port plus the weight stream towards
// the multiplier array. master = fetch sequencer, slave = table/consumer side.
interface cnn_layer_accel_awe_weight_fetch_if #(
  parameter int WIDTH   = 32,
  parameter int W_DEPTH = 8
);
  logic [W_DEPTH-1:0] tbl_addr;
  logic               tbl_rd;
  logic [WIDTH-1:0]   tbl_dout;
  logic [WIDTH-1:0]   wght_data;
  logic               wght_valid;
  logic               wght_last;
  logic               wght_ready;

  modport master (
    output tbl_addr, tbl_rd, wght_data, wght_valid, wght_last,
    input  tbl_dout, wght_ready
  );

  modport slave (
    input  tbl_addr, tbl_rd, wght_data, wght_valid, wght_last,
    output tbl_dout, wght_ready
  );
endinterface

// File: rtl/cnn_layer_accel_awe_wght_skid_fifo.sv
// Two-entry FIFO of {last, data} that absorbs the table's read latency.
// Flush empties it in one cycle and wins over push/pop.
module cnn_layer_accel_awe_wght_skid_fifo
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    occ_o,
  output logic          empty_o,
  output logic          full_o
);
  logic [DW-1:0] mem_q [AWE_BUF_DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    occ_q;

  // Storage, pointers and occupancy; push/pop together keep occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AWE_BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
  assign empty_o = (occ_q == 2'd0);
  assign full_o  = (occ_q == 2'(AWE_BUF_DEPTH));

endmodule

// File: rtl/cnn_layer_accel_awe_weight_fetch.sv
// AWE weight fetch sequencer: walks the weight table kernel by kernel,
// streams words with a per-kernel last marker, credit-limited so that at
// most two words are ever buffered or in flight.
// Optional macro CNN_AWE_WGHT_FETCH_STALL_CNT_EN adds the stall_cnt_o counter.
module cnn_layer_accel_awe_weight_fetch
  import cnn_layer_accel_awe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int W_DEPTH = 8,
  parameter int KSIZE   = AWE_KSIZE_DEF,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               start_i,
  input  logic [W_DEPTH-1:0] base_addr_i,
  input  logic [CNT_W-1:0]   num_kernels_i,
  input  logic [CNT_W-1:0]   num_repeats_i,
  output logic               busy_o,
  output logic               done_o,
`ifdef CNN_AWE_WGHT_FETCH_STALL_CNT_EN
  output logic [31:0]        stall_cnt_o,
`endif
  cnn_layer_accel_awe_weight_fetch_if.master bus
);
  localparam int EW = $clog2(KSIZE + 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(KSIZE - 1);
  localparam int DW = WIDTH + 1;

  awe_state_e         state_q, state_d;
  logic [W_DEPTH-1:0] addr_q, addr_d, base_q, base_d;
  logic [EW-1:0]      elem_q, elem_d;
  logic [CNT_W-1:0]   kern_q, kern_d, rep_q, rep_d, nk_q, nk_d, nrep_q, nrep_d;
  logic               rd_q, rd_last_q;

  logic [DW-1:0] fifo_dout;
  logic [1:0]    fifo_occ;
  logic          fifo_empty, fifo_full, fifo_push, pop;
  logic [2:0]    pending;
  logic          rd_issue, last_elem, last_kern, last_rep;

  assign pop       = bus.wght_valid && bus.wght_ready;
  assign pending   = {1'b0, fifo_occ} + {2'b00, rd_q};
  assign last_elem = (elem_q == ELEM_LAST);
  assign last_kern = (kern_q == nk_q - CNT_W'(1));
  assign last_rep  = (rep_q == nrep_q - CNT_W'(1));
  // A read is allowed only while the buffer plus in-flight reads, less this
  // cycle's pop, leaves a free slot; an abort suppresses any new read.
  assign rd_issue  = (state_q == ST_FETCH) && ((pending - {2'b00, pop}) < 3'd2) && !clr_i;

  // Next-state, address walk and counter sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    elem_d  = elem_q;
    kern_d  = kern_q;
    rep_d   = rep_q;
    nk_d    = nk_q;
    nrep_d  = nrep_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d  = base_addr_i;
          addr_d  = base_addr_i;
          elem_d  = '0;
          kern_d  = '0;
          rep_d   = '0;
          nk_d    = num_kernels_i;
          nrep_d  = (num_repeats_i == '0) ? CNT_W'(1) : num_repeats_i;
          state_d = (num_kernels_i == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rd_issue) begin
          addr_d = addr_q + W_DEPTH'(1);
          if (last_elem) begin
            elem_d = '0;
            if (last_kern) begin
              kern_d = '0;
              rep_d  = rep_q + CNT_W'(1);
              addr_d = base_q;
              if (last_rep) state_d = ST_DRAIN;
            end else begin
              kern_d = kern_q + CNT_W'(1);
            end
          end else begin
            elem_d = elem_q + EW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !rd_q) state_d = ST_FINISH;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr_i) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      base_d  = '0;
      elem_d  = '0;
      kern_d  = '0;
      rep_d   = '0;
      nk_d    = '0;
      nrep_d  = '0;
    end
  end

  // Sequencer state plus the one-cycle read-latency tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      elem_q    <= '0;
      kern_q    <= '0;
      rep_q     <= '0;
      nk_q      <= '0;
      nrep_q    <= '0;
      rd_q      <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      elem_q    <= elem_d;
      kern_q    <= kern_d;
      rep_q     <= rep_d;
      nk_q      <= nk_d;
      nrep_q    <= nrep_d;
      rd_q      <= rd_issue;
      rd_last_q <= rd_issue && last_elem;
    end
  end

  // Returning data is dropped on abort; the full guard is a backstop only.
  assign fifo_push = rd_q && !clr_i && (!fifo_full || pop);

  cnn_layer_accel_awe_wght_skid_fifo #(.DW(DW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (clr_i),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .din_i   ({rd_last_q, bus.tbl_dout}),
    .dout_o  (fifo_dout),
    .occ_o   (fifo_occ),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.tbl_addr   = addr_q;
  assign bus.tbl_rd     = rd_issue;
  assign bus.wght_valid = !fifo_empty;
  assign bus.wght_data  = fifo_dout[WIDTH-1:0];
  assign bus.wght_last  = fifo_dout[WIDTH];
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_FINISH);

`ifdef CNN_AWE_WGHT_FETCH_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of stalled-output cycles during a job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (clr_i || (state_q == ST_IDLE && start_i)) begin
      stall_q <= '0;
    end else if (busy_o && bus.wght_valid && !bus.wght_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: doc/cnn_layer_accel_awe_weight_fetch.md
# cnn_layer_accel_awe_weight_fetch

Weight fetch sequencer for the AWE engine. It reads kernel weights out of the dual-port weight table through the table's read port. It streams them to the AWE multiplier array over a valid/ready interface, in kernel order, with a per-kernel `last` marker. Because the table has a registered read (one-cycle latency), the block absorbs it with a credit-controlled 2-entry output buffer so downstream backpressure never drops or duplicates a word.

## Interface
- `WIDTH`, 32, weight word width; matches the table.
- `W_DEPTH`, 8, table address width.
- `KSIZE`, 9, words per kernel (3x3).
- `CNT_W`, 8, width of the kernel-count and repeat-count fields.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous abort: return to IDLE and flush the buffer.
- `start`  in  1  one-cycle request; ignored unless in IDLE.
- `base_addr`  in  W_DEPTH  first table address; sampled on `start`.
- `num_kernels`  in  CNT_W  kernels per pass; sampled on `start`.
- `num_repeats`  in  CNT_W  passes over the kernel set; 0 is treated as 1; sampled on `start`.
- `tbl_addr`  out  W_DEPTH  drives the table read-port address.
- `tbl_rd`  out  1  read issued this cycle; the table's write enable stays tied 0.
- `tbl_dout`  in  WIDTH  table read data, valid one cycle after `tbl_rd`.
- `wght_data`  out  WIDTH  weight word.
- `wght_valid`  out  1  `wght_data` is valid.
- `wght_last`  out  1  word is the final word of a kernel.
- `wght_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse after the last word has been accepted.

## Operation
- Reset and `clr` value of every output: 0.
  - `tbl_addr` resets to 0.
  - The buffer is emptied.
- States:
  - IDLE: on `start`, latch the parameters and clear the counters. Go to FETCH, or to FINISH if `num_kernels`==0.
  - FETCH: issue a read whenever credits allow. After the read of the final word of the final repeat, go to DRAIN.
  - DRAIN: wait for the buffer to empty and no read to be in flight, then go to FINISH.
  - FINISH: pulse `done`, drop `busy`, return to IDLE.
- Credit rule: issue `tbl_rd` only when (buffer occupancy + reads in flight − pop this cycle) < 2.
  - Full-rate streaming is sustained when `wght_ready` is held high.
  - The buffer can never overflow.
- Address generation:
  - `tbl_addr` = `base_addr` + kernel_idx*KSIZE + elem_idx, computed modulo 2^W_DEPTH. Wrap-around past the top of the table is legal and silent.
  - elem_idx counts 0..KSIZE-1, then kernel_idx increments. After the last kernel, the repeat counter increments and kernel_idx returns to 0.
- `wght_last` is carried alongside each read: it is set when elem_idx==KSIZE-1.
- The buffer is a 2-entry FIFO. It is written on the cycle `tbl_dout` is valid and popped on `wght_valid && wght_ready`. Push and pop in the same cycle are legal and leave the occupancy unchanged.
- `wght_data`/`wght_last` stay stable while `wght_valid && !wght_ready`.
- `clr` wins over every other input in the same cycle. A read still in flight when `clr` is applied is discarded.
- Asynchronous reset asserted mid-transfer: everything returns to its reset value immediately, and no `done` is issued.

## Timing
- `start` is sampled at cycle 0.
- First `tbl_rd` at cycle 1, data in the buffer at the end of cycle 2, first `wght_valid` at cycle 3.
- With `wght_ready` held high, one word per cycle. The total transfer is num_kernels*KSIZE*max(1,num_repeats) words.
- `done` pulses the cycle after the final handshake plus one (through DRAIN→FINISH).
- `start` with `num_kernels`==0: `busy` high cycle 1, `done` pulse cycle 1.

## Configuration
- `CNN_AWE_WGHT_FETCH_STALL_CNT_EN`
  - When defined: adds output `stall_cnt` (32 bits). It counts the cycles with `wght_valid && !wght_ready` while `busy`, saturates at all-ones, and clears on `start` and `clr`.
  - When undefined: the port and the counter are absent and behaviour is otherwise identical.

## Structure
- The shared `cnn_layer_accel_awe_pkg` holds:
  - the state encoding (IDLE, FETCH, DRAIN, FINISH);
  - the buffer depth constant (2);
  - the default `KSIZE`.
- One sub-module, `cnn_layer_accel_awe_wght_skid_fifo`: the 2-entry FIFO of {last, data} with push, pop, occupancy and empty/full.

## Test plan
- base=0x10, kernels=2, repeats=1, table[i]=i, `wght_ready`=1 → 18 words 0x10..0x21 on cycles 3..20; `wght_last` on 0x18 and 0x21; `done` once.
- Same setup, `wght_ready` toggling 1-0-1-0 → identical data sequence with no drops or duplicates; never more than 2 reads outstanding.
- base=0xFC, kernels=1 → addresses 0xFC..0xFF, 0x00..0x04 (wrap).
- kernels=1, repeats=3 → the same 9 words three times; 3 `last` markers; `done` once.
- `clr` asserted mid-stream with `wght_ready`=0 → `wght_valid` is 0 next cycle, state is IDLE, no `done`; a new `start` runs cleanly.
- `start` with kernels=0 → `done` in cycle 1 and no `tbl_rd`; `start` during `busy` is ignored.
